cache_refill_controller: RTL and testbench

- Miss-side consumer of the per-set LRU replacement state.
- On a cache miss it reads the least-recently-accessed way for the set and inspects that victim's tag state.
- It writes back the victim if it is dirty, fetches the missing line, and installs the new tag.
- It then issues the LRU access update that makes the filled way most-recent.
- Sits between the cache tag array, the LRU counter and the memory-side request interface.

---
 rtl/cache_refill_controller_if.sv | 48 ++++
 rtl/cache_refill_controller.sv | 105 ++++++++++
 tb/tb_cache_refill_controller.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_controller_if.sv
// Miss, tag-array, LRU and memory-side signals of the refill controller.
// The master modport is the controller; the slave modport is its environment.
interface cache_refill_controller_if #(
  parameter int WAY_NUM         = 4,
  parameter int INDEX_BIT_WIDTH = 2,
  parameter int TAG_BIT_WIDTH   = 8
);
  localparam int WAY_W  = $clog2(WAY_NUM);
  localparam int ADDR_W = TAG_BIT_WIDTH + INDEX_BIT_WIDTH;

  logic                       missReq;
  logic [INDEX_BIT_WIDTH-1:0] missIndex;
  logic [TAG_BIT_WIDTH-1:0]   missTag;
  logic                       missAck;
  logic [INDEX_BIT_WIDTH-1:0] lruIndex;
  logic [WAY_W-1:0]           victimWay;
  logic                       victimValid;
  logic                       victimDirty;
  logic [TAG_BIT_WIDTH-1:0]   victimTag;
  logic                       wbReq;
  logic [ADDR_W-1:0]          wbAddr;
  logic                       wbAck;
  logic                       fillReq;
  logic [ADDR_W-1:0]          fillAddr;
  logic                       fillAck;
  logic                       fillValid;
  logic                       tagWe;
  logic [WAY_W-1:0]           tagWeWay;
  logic [TAG_BIT_WIDTH-1:0]   tagWeTag;
  logic                       lruAccess;
  logic [WAY_W-1:0]           lruAccessWay;
  logic                       refillDone;
  logic                       busy;

  modport master (
    input  missReq, missIndex, missTag, victimWay, victimValid, victimDirty,
           victimTag, wbAck, fillAck, fillValid,
    output missAck, lruIndex, wbReq, wbAddr, fillReq, fillAddr, tagWe,
           tagWeWay, tagWeTag, lruAccess, lruAccessWay, refillDone, busy
  );

  modport slave (
    output missReq, missIndex, missTag, victimWay, victimValid, victimDirty,
           victimTag, wbAck, fillAck, fillValid,
    input  missAck, lruIndex, wbReq, wbAddr, fillReq, fillAddr, tagWe,
           tagWeWay, tagWeTag, lruAccess, lruAccessWay, refillDone, busy
  );
endinterface

// File: rtl/cache_refill_controller.sv
// Miss-side refill sequencer: picks the LRU victim, writes it back if dirty,
// fetches the missing line, installs the tag and marks the way most-recent.
module cache_refill_controller #(
  parameter int WAY_NUM         = 4,
  parameter int INDEX_BIT_WIDTH = 2,
  parameter int TAG_BIT_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  cache_refill_controller_if.master bus
);
  localparam int WAY_W = $clog2(WAY_NUM);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SELECT    = 3'd1;
  localparam logic [2:0] WB_REQ    = 3'd2;
  localparam logic [2:0] FILL_REQ  = 3'd3;
  localparam logic [2:0] FILL_WAIT = 3'd4;
  localparam logic [2:0] INSTALL   = 3'd5;

  logic [2:0]                 state_q, state_d;
  logic [INDEX_BIT_WIDTH-1:0] index_q, index_d;
  logic [TAG_BIT_WIDTH-1:0]   tag_q, tag_d;
  logic [WAY_W-1:0]           victim_way_q, victim_way_d;
  logic [TAG_BIT_WIDTH-1:0]   victim_tag_q, victim_tag_d;
  logic [WAY_W-1:0]           inst_way_q, inst_way_d;
  logic [TAG_BIT_WIDTH-1:0]   inst_tag_q, inst_tag_d;
  logic                       idle;
  logic                       install;

  assign idle    = (state_q == IDLE);
  assign install = (state_q == INSTALL);

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    tag_d        = tag_q;
    victim_way_d = victim_way_q;
    victim_tag_d = victim_tag_q;
    inst_way_d   = inst_way_q;
    inst_tag_d   = inst_tag_q;
    case (state_q)
      IDLE: begin
        if (bus.missReq) begin
          state_d = SELECT;
          index_d = bus.missIndex;
          tag_d   = bus.missTag;
        end
      end
      SELECT: begin
        victim_way_d = bus.victimWay;
        victim_tag_d = bus.victimTag;
        // An invalid line never needs write-back, whatever its dirty bit says.
        state_d = (bus.victimValid && bus.victimDirty) ? WB_REQ : FILL_REQ;
      end
      WB_REQ:   if (bus.wbAck)   state_d = FILL_REQ;
      FILL_REQ: if (bus.fillAck) state_d = FILL_WAIT;
      FILL_WAIT: begin
        if (bus.fillValid) begin
          state_d = INSTALL;
          // Install fields live in their own registers so they stay put until the next install.
          inst_way_d = victim_way_q;
          inst_tag_d = tag_q;
        end
      end
      INSTALL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      tag_q        <= '0;
      victim_way_q <= '0;
      victim_tag_q <= '0;
      inst_way_q   <= '0;
      inst_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      tag_q        <= tag_d;
      victim_way_q <= victim_way_d;
      victim_tag_q <= victim_tag_d;
      inst_way_q   <= inst_way_d;
      inst_tag_q   <= inst_tag_d;
    end
  end

  // Outputs fed straight from inputs are gated so everything reads 0 while reset is held.
  assign bus.missAck      = idle & bus.missReq & rst;
  assign bus.lruIndex     = !rst ? '0 : (idle ? bus.missIndex : index_q);
  assign bus.wbReq        = (state_q == WB_REQ);
  assign bus.wbAddr       = {victim_tag_q, index_q};
  assign bus.fillReq      = (state_q == FILL_REQ);
  assign bus.fillAddr     = {tag_q, index_q};
  assign bus.tagWe        = install;
  assign bus.tagWeWay     = inst_way_q;
  assign bus.tagWeTag     = inst_tag_q;
  assign bus.lruAccess    = install;
  assign bus.lruAccessWay = inst_way_q;
  assign bus.refillDone   = install;
  assign bus.busy         = !idle;
endmodule

// File: tb/tb_cache_refill_controller.sv
// Self-checking bench for cache_refill_controller: directed scenarios plus
// randomized transactions checked against a cycle-count model of each refill.
module tb_cache_refill_controller;
  localparam int WAY_NUM = 4;
  localparam int IW      = 2;
  localparam int TW      = 8;
  localparam int WW      = $clog2(WAY_NUM);
  localparam int NRAND   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_refill_controller_if #(.WAY_NUM(WAY_NUM), .INDEX_BIT_WIDTH(IW), .TAG_BIT_WIDTH(TW)) bus_if ();

  cache_refill_controller #(.WAY_NUM(WAY_NUM), .INDEX_BIT_WIDTH(IW), .TAG_BIT_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the install outputs must hold between installs.
  logic [WW-1:0] exp_last_way = '0;
  logic [TW-1:0] exp_last_tag = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus_if.missReq     = 1'b0;
    bus_if.missIndex   = '0;
    bus_if.missTag     = '0;
    bus_if.victimWay   = '0;
    bus_if.victimValid = 1'b0;
    bus_if.victimDirty = 1'b0;
    bus_if.victimTag   = '0;
    bus_if.wbAck       = 1'b0;
    bus_if.fillAck     = 1'b0;
    bus_if.fillValid   = 1'b0;
  endtask

  // Advance to the next falling edge, drop single-cycle pulses and let the
  // victim inputs wander (the controller must have latched them already).
  task automatic cyc(input logic [WW-1:0] wway, input logic [TW-1:0] wtag);
    @(negedge clk);
    bus_if.wbAck       = 1'b0;
    bus_if.fillAck     = 1'b0;
    bus_if.fillValid   = 1'b0;
    bus_if.victimWay   = wway;
    bus_if.victimTag   = wtag;
    bus_if.victimDirty = 1'b0;
    bus_if.victimValid = 1'($urandom_range(0, 1));
  endtask

  // One refill transaction. Expected timing comes from the refill rules:
  // ack cycle, one SELECT cycle, wb_d+1 write-back cycles only for a valid
  // dirty victim, fa_d+1 fill-request cycles, fv_d+1 wait cycles, one install.
  task automatic run_txn(
    input logic [IW-1:0] idx, input logic [TW-1:0] tag,
    input logic [WW-1:0] way, input logic valid, input logic dirty,
    input logic [TW-1:0] vtag, input int wb_d, input int fa_d, input int fv_d,
    input logic spur, input logic [WW-1:0] new_way,
    input logic hold_next, input logic [IW-1:0] nidx, input logic [TW-1:0] ntag);
    logic wb;
    wb = valid & dirty;

    @(negedge clk);
    bus_if.wbAck = 1'b0; bus_if.fillAck = 1'b0; bus_if.fillValid = 1'b0;
    bus_if.missReq = 1'b1; bus_if.missIndex = idx; bus_if.missTag = tag;
    bus_if.victimWay = way; bus_if.victimValid = valid;
    bus_if.victimDirty = dirty; bus_if.victimTag = vtag;
    #1;
    chk("missAck", 32'(bus_if.missAck), 32'd1);
    chk("idle_lruIndex", 32'(bus_if.lruIndex), 32'(idx));
    chk("idle_busy", 32'(bus_if.busy), 32'd0);
    chk("idle_tagWe", 32'(bus_if.tagWe), 32'd0);
    chk("idle_refillDone", 32'(bus_if.refillDone), 32'd0);
    chk("held_tagWeWay", 32'(bus_if.tagWeWay), 32'(exp_last_way));
    chk("held_tagWeTag", 32'(bus_if.tagWeTag), 32'(exp_last_tag));

    @(negedge clk);
    if (hold_next) begin
      bus_if.missReq = 1'b1; bus_if.missIndex = nidx; bus_if.missTag = ntag;
    end else begin
      bus_if.missReq = 1'b0;
    end
    #1;
    chk("sel_busy", 32'(bus_if.busy), 32'd1);
    chk("sel_lruIndex", 32'(bus_if.lruIndex), 32'(idx));
    chk("sel_noreq", 32'({bus_if.wbReq, bus_if.fillReq}), 32'd0);
    if (hold_next) chk("sel_blocked_ack", 32'(bus_if.missAck), 32'd0);

    if (wb) begin
      for (int k = 0; k <= wb_d; k++) begin
        cyc(new_way, ~vtag);
        bus_if.wbAck = (k == wb_d);
        #1;
        chk("wbReq", 32'(bus_if.wbReq), 32'd1);
        chk("wbAddr", 32'(bus_if.wbAddr), 32'({vtag, idx}));
        chk("wb_no_fillReq", 32'(bus_if.fillReq), 32'd0);
        if (hold_next) chk("wb_blocked_ack", 32'(bus_if.missAck), 32'd0);
      end
    end

    for (int k = 0; k <= fa_d; k++) begin
      cyc(new_way, ~vtag);
      bus_if.fillAck   = (k == fa_d);
      bus_if.fillValid = spur && (k == 0);
      #1;
      chk("fillReq", 32'(bus_if.fillReq), 32'd1);
      chk("fillAddr", 32'(bus_if.fillAddr), 32'({tag, idx}));
      chk("fr_no_wbReq", 32'(bus_if.wbReq), 32'd0);
      chk("fr_no_tagWe", 32'(bus_if.tagWe), 32'd0);
    end

    for (int k = 0; k <= fv_d; k++) begin
      cyc(new_way, ~vtag);
      bus_if.fillValid = (k == fv_d);
      #1;
      chk("fw_busy", 32'(bus_if.busy), 32'd1);
      chk("fw_no_req", 32'({bus_if.wbReq, bus_if.fillReq}), 32'd0);
      chk("fw_no_install", 32'({bus_if.tagWe, bus_if.lruAccess, bus_if.refillDone}), 32'd0);
      if (hold_next) chk("fw_blocked_ack", 32'(bus_if.missAck), 32'd0);
    end

    cyc(new_way, ~vtag);
    #1;
    chk("tagWe", 32'(bus_if.tagWe), 32'd1);
    chk("tagWeWay", 32'(bus_if.tagWeWay), 32'(way));
    chk("tagWeTag", 32'(bus_if.tagWeTag), 32'(tag));
    chk("lruAccess", 32'(bus_if.lruAccess), 32'd1);
    chk("lruAccessWay", 32'(bus_if.lruAccessWay), 32'(way));
    chk("refillDone", 32'(bus_if.refillDone), 32'd1);
    chk("inst_lruIndex", 32'(bus_if.lruIndex), 32'(idx));
    if (hold_next) chk("inst_blocked_ack", 32'(bus_if.missAck), 32'd0);
    exp_last_way = way;
    exp_last_tag = tag;
  endtask

  logic [IW-1:0] r_idx   [NRAND];
  logic [TW-1:0] r_tag   [NRAND];
  logic [WW-1:0] r_way   [NRAND];
  logic [WW-1:0] r_nway  [NRAND];
  logic [TW-1:0] r_vtag  [NRAND];
  logic          r_valid [NRAND];
  logic          r_dirty [NRAND];
  logic          r_spur  [NRAND];
  logic          r_hold  [NRAND];
  int            r_wbd   [NRAND];
  int            r_fad   [NRAND];
  int            r_fvd   [NRAND];

  initial begin
    clear_inputs();
    bus_if.missReq   = 1'b1;
    bus_if.missIndex = 2'd3;
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_missAck", 32'(bus_if.missAck), 32'd0);
    chk("rst_lruIndex", 32'(bus_if.lruIndex), 32'd0);
    chk("rst_reqs", 32'({bus_if.wbReq, bus_if.fillReq}), 32'd0);
    chk("rst_install", 32'({bus_if.tagWe, bus_if.lruAccess, bus_if.refillDone}), 32'd0);
    chk("rst_tagWeWay", 32'(bus_if.tagWeWay), 32'd0);
    @(negedge clk);
    bus_if.missReq = 1'b0;
    rst = 1'b1;

    // Clean miss at minimum latency.
    run_txn(2'd2, 8'h5A, 2'd1, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1'b0, 2'd1, 1'b0, 2'd0, 8'h00);
    // Dirty victim with write-back ack delayed three cycles.
    run_txn(2'd0, 8'h33, 2'd3, 1'b1, 1'b1, 8'h11, 3, 0, 0, 1'b0, 2'd3, 1'b0, 2'd0, 8'h00);
    // Invalid but dirty victim: no write-back.
    run_txn(2'd1, 8'h44, 2'd0, 1'b0, 1'b1, 8'h99, 2, 0, 0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);
    // Stalled fill with a spurious fillValid during the request phase.
    run_txn(2'd3, 8'hA5, 2'd2, 1'b0, 1'b0, 8'h00, 0, 5, 7, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00);
    // Second miss held through a refill whose victim way also moves 1->2 after SELECT.
    run_txn(2'd2, 8'h0F, 2'd1, 1'b1, 1'b0, 8'h22, 0, 1, 2, 1'b0, 2'd2, 1'b1, 2'd1, 8'hC3);
    run_txn(2'd1, 8'hC3, 2'd2, 1'b1, 1'b1, 8'h7E, 1, 0, 1, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00);

    // Asynchronous reset in FILL_WAIT abandons the refill.
    @(negedge clk);
    bus_if.missReq = 1'b1; bus_if.missIndex = 2'd3; bus_if.missTag = 8'h77;
    bus_if.victimWay = 2'd2; bus_if.victimValid = 1'b1; bus_if.victimDirty = 1'b0;
    @(negedge clk);
    bus_if.missReq = 1'b0;
    @(negedge clk);
    bus_if.fillAck = 1'b1;
    @(negedge clk);
    bus_if.fillAck = 1'b0;
    #1 chk("ar_pre_busy", 32'(bus_if.busy), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", 32'(bus_if.busy), 32'd0);
    chk("ar_reqs", 32'({bus_if.wbReq, bus_if.fillReq}), 32'd0);
    chk("ar_install", 32'({bus_if.tagWe, bus_if.lruAccess, bus_if.refillDone}), 32'd0);
    chk("ar_tagWeWay", 32'(bus_if.tagWeWay), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.fillValid = 1'b1;
    exp_last_way = '0;
    exp_last_tag = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("ar_late_fv_tagWe", 32'(bus_if.tagWe), 32'd0);
      chk("ar_late_fv_busy", 32'(bus_if.busy), 32'd0);
    end
    bus_if.fillValid = 1'b0;

    // Randomized transactions; a held follow-on miss is always the next entry.
    for (int i = 0; i < NRAND; i++) begin
      r_idx[i]   = IW'($urandom);
      r_tag[i]   = TW'($urandom);
      r_way[i]   = WW'($urandom);
      r_nway[i]  = WW'($urandom);
      r_vtag[i]  = TW'($urandom);
      r_valid[i] = 1'($urandom_range(0, 1));
      r_dirty[i] = 1'($urandom_range(0, 1));
      r_spur[i]  = 1'($urandom_range(0, 1));
      r_hold[i]  = (i < NRAND - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      r_wbd[i]   = $urandom_range(0, 4);
      r_fad[i]   = $urandom_range(0, 4);
      r_fvd[i]   = $urandom_range(0, 4);
    end
    for (int i = 0; i < NRAND; i++) begin
      run_txn(r_idx[i], r_tag[i], r_way[i], r_valid[i], r_dirty[i], r_vtag[i],
              r_wbd[i], r_fad[i], r_fvd[i], r_spur[i], r_nway[i], r_hold[i],
              r_idx[(i + 1) % NRAND], r_tag[(i + 1) % NRAND]);
    end

    @(negedge clk);
    clear_inputs();
    #1;
    chk("end_idle", 32'(bus_if.busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
